// File: rtl/tug_referee.sv
// Tug-of-war game controller: turns key rising edges into rope moves,
// detects round wins, keeps per-player scores and ends the match at SCORE_MAX.
module tug_referee #(
    parameter int N_LIGHTS  = 9,
    parameter int SCORE_MAX = 7,
    parameter int SCORE_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p_l,
    input  logic                p_r,
    output logic [N_LIGHTS-1:0] lights,
    output logic [SCORE_W-1:0]  score_l,
    output logic [SCORE_W-1:0]  score_r,
    output logic [1:0]          winner,
    output logic                match_over
);

    localparam int CENTER = (N_LIGHTS - 1) / 2;
    localparam int POS_W  = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1;

    localparam logic [POS_W-1:0]    POS_CENTER    = POS_W'(CENTER);
    localparam logic [POS_W-1:0]    POS_MAX       = POS_W'(N_LIGHTS - 1);
    localparam logic [POS_W-1:0]    POS_MIN       = '0;
    localparam logic [N_LIGHTS-1:0] LIGHTS_CENTER = N_LIGHTS'(1) << CENTER;
    localparam logic [N_LIGHTS-1:0] LIGHT_LEFT    = N_LIGHTS'(1) << (N_LIGHTS - 1);
    localparam logic [N_LIGHTS-1:0] LIGHT_RIGHT   = N_LIGHTS'(1);
    localparam logic [SCORE_W-1:0]  SCORE_LIMIT   = SCORE_W'(SCORE_MAX);

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    generate
        if ((N_LIGHTS < 3) || (N_LIGHTS % 2 == 0)) begin : g_bad_lights
            $error("tug_referee: N_LIGHTS must be odd and >= 3");
        end
        if ((SCORE_MAX < 1) || (SCORE_MAX > (2 ** SCORE_W) - 1)) begin : g_bad_score
            $error("tug_referee: SCORE_MAX must fit in 1 .. 2**SCORE_W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        PLAY,
        WIN_L,
        WIN_R,
        DONE
    } state_t;

    state_t             state;
    logic [POS_W-1:0]   pos;
    logic               prev_l;
    logic               prev_r;
    logic               press_l;
    logic               press_r;
    logic [SCORE_W-1:0] score_l_inc;
    logic [SCORE_W-1:0] score_r_inc;

    // A held key yields exactly one press; a tie in the same cycle cancels below.
    assign press_l     = p_l & ~prev_l;
    assign press_r     = p_r & ~prev_r;
    assign score_l_inc = score_l + SCORE_W'(1);
    assign score_r_inc = score_r + SCORE_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PLAY;
            pos        <= POS_CENTER;
            lights     <= LIGHTS_CENTER;
            score_l    <= '0;
            score_r    <= '0;
            winner     <= WIN_NONE;
            match_over <= 1'b0;
            prev_l     <= 1'b0;
            prev_r     <= 1'b0;
        end else begin
            prev_l <= p_l;
            prev_r <= p_r;
            case (state)
                PLAY: begin
                    if (press_l && !press_r) begin
                        if (pos == POS_MAX) begin
                            score_l <= score_l_inc;
                            winner  <= WIN_LEFT;
                            lights  <= LIGHT_LEFT;
                            if (score_l_inc == SCORE_LIMIT) begin
                                state      <= DONE;
                                match_over <= 1'b1;
                            end else begin
                                state <= WIN_L;
                            end
                        end else begin
                            pos    <= pos + POS_W'(1);
                            lights <= lights << 1;
                        end
                    end else if (press_r && !press_l) begin
                        if (pos == POS_MIN) begin
                            score_r <= score_r_inc;
                            winner  <= WIN_RIGHT;
                            lights  <= LIGHT_RIGHT;
                            if (score_r_inc == SCORE_LIMIT) begin
                                state      <= DONE;
                                match_over <= 1'b1;
                            end else begin
                                state <= WIN_R;
                            end
                        end else begin
                            pos    <= pos - POS_W'(1);
                            lights <= lights >> 1;
                        end
                    end
                end
                WIN_L, WIN_R: begin
                    // Both keys must be up before the next round, so no press carries over.
                    if (!p_l && !p_r) begin
                        state  <= PLAY;
                        pos    <= POS_CENTER;
                        lights <= LIGHTS_CENTER;
                        winner <= WIN_NONE;
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= PLAY;
                end
            endcase
        end
    end

endmodule
